core_sequencer: RTL and testbench

Job-level controller for the 4x4 systolic matmul core. It accepts one weight tile and a programmable number of activation tiles through valid/ready handshakes. For each activation tile it pulses the core's `weight_load`/`act_load` strobes, waits a fixed compute/drain latency, then presents the result to downstream with a valid/ready handshake. It sits between the tile memory/router front end and the core instance, and is the only driver of the core's load strobes.

---
 rtl/core_seq_pkg.sv | 16 +
 rtl/core_sequencer_if.sv | 30 +++
 rtl/seq_counter.sv | 26 ++
 rtl/core_sequencer.sv | 130 +++++++++++++
 tb/tb_core_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_seq_pkg.sv
// Shared types and constants for the matmul core job sequencer and its helpers.
package core_seq_pkg;

  localparam int unsigned DEF_COMPUTE_CYCLES = 11;
  localparam int unsigned CNT_W              = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_A,
    COMPUTE,
    RESULT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/core_sequencer_if.sv
// Job, tile and result handshakes between the front end and the core sequencer.
interface core_sequencer_if #(
  parameter int unsigned TILE_W = 8
);

  logic              start;
  logic [TILE_W-1:0] num_tiles;
  logic              w_valid;
  logic              w_ready;
  logic              a_valid;
  logic              a_ready;
  logic              weight_load;
  logic              act_load;
  logic              res_valid;
  logic              res_ready;
  logic [TILE_W-1:0] tile_idx;
  logic              busy;
  logic              done;

  modport master (
    output start, num_tiles, w_valid, a_valid, res_ready,
    input  w_ready, a_ready, weight_load, act_load, res_valid, tile_idx, busy, done
  );

  modport slave (
    input  start, num_tiles, w_valid, a_valid, res_ready,
    output w_ready, a_ready, weight_load, act_load, res_valid, tile_idx, busy, done
  );

endinterface

// File: rtl/seq_counter.sv
// Loadable down-counter that saturates at zero; shared with the tile-memory controller.
module seq_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec && (value != '0)) begin
      value <= value - WIDTH'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/core_sequencer.sv
// Job-level controller for the 4x4 systolic core: one weight tile, N activation
// tiles, fixed compute latency per tile, result handed downstream per tile.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int unsigned TILE_W         = 8,
  parameter int unsigned COMPUTE_CYCLES = DEF_COMPUTE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  core_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(COMPUTE_CYCLES - 1);

  seq_state_t        state;
  seq_state_t        state_nx;
  logic [TILE_W-1:0] tile_cnt;
  logic [TILE_W-1:0] tile_idx_q;
  logic              last_tile;

  logic [CNT_W-1:0]  cnt_value;
  logic              cnt_zero;
  logic              cnt_load;
  logic              cnt_dec;

  logic              w_ready;
  logic              a_ready;
  logic              weight_load;
  logic              act_load;
  logic              res_valid;
  logic              done;

  seq_counter #(
    .WIDTH (CNT_W)
  ) u_lat_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (LAT_INIT),
    .dec        (cnt_dec),
    .value      (cnt_value),
    .zero       (cnt_zero)
  );

  assign last_tile = (tile_idx_q == (tile_cnt - TILE_W'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    w_ready     = 1'b0;
    a_ready     = 1'b0;
    weight_load = 1'b0;
    act_load    = 1'b0;
    res_valid   = 1'b0;
    done        = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = (bus.num_tiles != '0) ? LOAD_W : DONE;
        end
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (bus.w_valid) begin
          weight_load = 1'b1;
          state_nx    = LOAD_A;
        end
      end
      LOAD_A: begin
        a_ready = 1'b1;
        if (bus.a_valid) begin
          act_load = 1'b1;
          cnt_load = 1'b1;
          state_nx = (COMPUTE_CYCLES <= 1) ? RESULT : COMPUTE;
        end
      end
      COMPUTE: begin
        cnt_dec = 1'b1;
        // Leave on the step that takes the counter to 0, so RESULT coincides
        // with zero and the act_load-to-res_valid latency is COMPUTE_CYCLES.
        if ((cnt_value == CNT_W'(1)) || cnt_zero) begin
          state_nx = RESULT;
        end
      end
      RESULT: begin
        res_valid = 1'b1;
        if (bus.res_ready) begin
          state_nx = last_tile ? DONE : LOAD_A;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_cnt   <= '0;
      tile_idx_q <= '0;
    end else if ((state == IDLE) && bus.start) begin
      tile_cnt   <= bus.num_tiles;
      tile_idx_q <= '0;
    end else if ((state == RESULT) && bus.res_ready && !last_tile) begin
      tile_idx_q <= tile_idx_q + TILE_W'(1);
    end
  end

  assign bus.w_ready     = w_ready;
  assign bus.a_ready     = a_ready;
  assign bus.weight_load = weight_load;
  assign bus.act_load    = act_load;
  assign bus.res_valid   = res_valid;
  assign bus.done        = done;
  assign bus.busy        = (state != IDLE);
  assign bus.tile_idx    = tile_idx_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-cycle traces of strobes/handshakes
// compared against hand-derived cycle positions (COMPUTE_CYCLES = 11).
module tb_core_sequencer;

  localparam int unsigned TW = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  core_sequencer_if #(.TILE_W(TW)) bus ();

  core_sequencer #(
    .TILE_W         (TW),
    .COMPUTE_CYCLES (11)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [63:0]   wl_v, al_v, rv_v, dn_v, by_v;
  logic [TW-1:0] tidx [0:63];

  function automatic logic [63:0] bit_at(input int c);
    return 64'd1 << c;
  endfunction

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Cycle 0 is the IDLE cycle where start is accepted; inputs are driven just
  // after each rising edge and outputs sampled on the falling edge.
  task automatic run_job(input logic [TW-1:0] n, input int w_delay, input int stall,
                         input int start_at, input int ncyc);
    int stall_left = stall;
    wl_v = '0; al_v = '0; rv_v = '0; dn_v = '0; by_v = '0;
    for (int i = 0; i < 64; i++) tidx[i] = '0;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.num_tiles = n;
    bus.w_valid   = (w_delay == 0);
    bus.a_valid   = 1'b1;
    bus.res_ready = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      bus.start     = (c == start_at);
      bus.num_tiles = TW'(8'h55);
      bus.w_valid   = (c >= 1 + w_delay);
      if (bus.res_valid && stall_left > 0) begin
        bus.res_ready = 1'b0;
        stall_left--;
      end else begin
        bus.res_ready = 1'b1;
      end
      @(negedge clk);
      wl_v[c] = bus.weight_load;
      al_v[c] = bus.act_load;
      rv_v[c] = bus.res_valid;
      dn_v[c] = bus.done;
      by_v[c] = bus.busy;
      tidx[c] = bus.tile_idx;
    end
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    reset = 1'b1;
    bus.start = 1'b0; bus.num_tiles = '0;
    bus.w_valid = 1'b1; bus.a_valid = 1'b1; bus.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    outs = {bus.busy, bus.done, bus.res_valid, bus.w_ready, bus.a_ready, bus.weight_load, bus.act_load};
    if (outs !== 7'b0) $display("FAIL reset_outs: got %b expected %b", outs, 7'b0);
    else n_pass++;
    n_total++;
    if (bus.tile_idx !== '0) $display("FAIL reset_tile_idx: got %0d expected 0", bus.tile_idx);
    else n_pass++;
    n_total++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_tile();
    run_job(1, 0, 0, 0, 18);
    if (wl_v !== bit_at(1)) $display("FAIL single_wl: got %h expected %h", wl_v, bit_at(1)); else n_pass++;
    n_total++;
    if (al_v !== bit_at(2)) $display("FAIL single_al: got %h expected %h", al_v, bit_at(2)); else n_pass++;
    n_total++;
    if (rv_v !== bit_at(13)) $display("FAIL single_rv: got %h expected %h", rv_v, bit_at(13)); else n_pass++;
    n_total++;
    if (dn_v !== bit_at(14)) $display("FAIL single_done: got %h expected %h", dn_v, bit_at(14)); else n_pass++;
    n_total++;
    if (by_v !== span(1, 14)) $display("FAIL single_busy: got %h expected %h", by_v, span(1, 14)); else n_pass++;
    n_total++;
    if (tidx[13] !== 8'd0) $display("FAIL single_tidx: got %0d expected 0", tidx[13]); else n_pass++;
    n_total++;
  endtask

  task automatic test_multi_tile();
    logic [63:0] exp_al = bit_at(2) | bit_at(14) | bit_at(26);
    logic [63:0] exp_rv = bit_at(13) | bit_at(25) | bit_at(37);
    run_job(3, 0, 0, 0, 42);
    if (wl_v !== bit_at(1)) $display("FAIL multi_wl: got %h expected %h", wl_v, bit_at(1)); else n_pass++;
    n_total++;
    if (al_v !== exp_al) $display("FAIL multi_al: got %h expected %h", al_v, exp_al); else n_pass++;
    n_total++;
    if (rv_v !== exp_rv) $display("FAIL multi_rv: got %h expected %h", rv_v, exp_rv); else n_pass++;
    n_total++;
    if (dn_v !== bit_at(38)) $display("FAIL multi_done: got %h expected %h", dn_v, bit_at(38)); else n_pass++;
    n_total++;
    if (by_v !== span(1, 38)) $display("FAIL multi_busy: got %h expected %h", by_v, span(1, 38)); else n_pass++;
    n_total++;
    if ({tidx[13], tidx[25], tidx[37]} !== {8'd0, 8'd1, 8'd2})
      $display("FAIL multi_tidx: got %0d,%0d,%0d expected 0,1,2", tidx[13], tidx[25], tidx[37]);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_res_stall();
    logic [63:0] exp_al = bit_at(2) | bit_at(19);
    logic [63:0] exp_rv = span(13, 18) | bit_at(30);
    logic        idx_ok = 1'b1;
    run_job(2, 0, 5, 0, 35);
    if (al_v !== exp_al) $display("FAIL stall_al: got %h expected %h", al_v, exp_al); else n_pass++;
    n_total++;
    if (rv_v !== exp_rv) $display("FAIL stall_rv: got %h expected %h", rv_v, exp_rv); else n_pass++;
    n_total++;
    if (dn_v !== bit_at(31)) $display("FAIL stall_done: got %h expected %h", dn_v, bit_at(31)); else n_pass++;
    n_total++;
    for (int c = 13; c <= 18; c++) if (tidx[c] !== 8'd0) idx_ok = 1'b0;
    if (!idx_ok || tidx[30] !== 8'd1)
      $display("FAIL stall_tidx: got first-result idx stable=%0d second=%0d expected stable=1 second=1", idx_ok, tidx[30]);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_zero_tiles();
    logic [63:0] hs = '0;
    run_job(0, 0, 0, 0, 4);
    hs = wl_v | al_v | rv_v;
    if (dn_v !== bit_at(1)) $display("FAIL zero_done: got %h expected %h", dn_v, bit_at(1)); else n_pass++;
    n_total++;
    if (hs !== 64'd0) $display("FAIL zero_handshakes: got %h expected %h", hs, 64'd0); else n_pass++;
    n_total++;
    if (by_v !== bit_at(1)) $display("FAIL zero_busy: got %h expected %h", by_v, bit_at(1)); else n_pass++;
    n_total++;
  endtask

  task automatic test_ignored_inputs();
    // Weight valid withheld until cycle 4, a_valid high throughout, start re-pulsed in COMPUTE.
    run_job(1, 3, 0, 8, 22);
    if (wl_v !== bit_at(4)) $display("FAIL ignore_wl: got %h expected %h", wl_v, bit_at(4)); else n_pass++;
    n_total++;
    if (al_v !== bit_at(5)) $display("FAIL ignore_al: got %h expected %h", al_v, bit_at(5)); else n_pass++;
    n_total++;
    if (rv_v !== bit_at(16)) $display("FAIL ignore_rv: got %h expected %h", rv_v, bit_at(16)); else n_pass++;
    n_total++;
    if (dn_v !== bit_at(17)) $display("FAIL ignore_done: got %h expected %h", dn_v, bit_at(17)); else n_pass++;
    n_total++;
    if (by_v !== span(1, 17)) $display("FAIL ignore_busy: got %h expected %h", by_v, span(1, 17)); else n_pass++;
    n_total++;
  endtask

  task automatic test_reset_midjob();
    logic [6:0]  outs;
    logic [63:0] exp_al = bit_at(2) | bit_at(14);
    logic [63:0] exp_rv = bit_at(13) | bit_at(25);
    run_job(2, 0, 0, 0, 18);
    if ({by_v[18], tidx[18]} !== {1'b1, 8'd1})
      $display("FAIL midjob_pre: got busy=%0d idx=%0d expected busy=1 idx=1", by_v[18], tidx[18]);
    else n_pass++;
    n_total++;
    #2 reset = 1'b1;
    #1;
    outs = {bus.busy, bus.done, bus.res_valid, bus.w_ready, bus.a_ready, bus.weight_load, bus.act_load};
    if (outs !== 7'b0) $display("FAIL midjob_outs: got %b expected %b", outs, 7'b0); else n_pass++;
    n_total++;
    if (bus.tile_idx !== '0) $display("FAIL midjob_tidx: got %0d expected 0", bus.tile_idx); else n_pass++;
    n_total++;
    @(negedge clk);
    @(negedge clk);
    if (bus.done !== 1'b0) $display("FAIL midjob_nodone: got %0d expected 0", bus.done); else n_pass++;
    n_total++;
    reset = 1'b0;
    @(negedge clk);
    run_job(2, 0, 0, 0, 30);
    if (al_v !== exp_al) $display("FAIL rerun_al: got %h expected %h", al_v, exp_al); else n_pass++;
    n_total++;
    if (rv_v !== exp_rv) $display("FAIL rerun_rv: got %h expected %h", rv_v, exp_rv); else n_pass++;
    n_total++;
    if ({wl_v, dn_v} !== {bit_at(1), bit_at(26)})
      $display("FAIL rerun_wl_done: got wl=%h done=%h expected wl=%h done=%h", wl_v, dn_v, bit_at(1), bit_at(26));
    else n_pass++;
    n_total++;
    if ({tidx[13], tidx[25]} !== {8'd0, 8'd1})
      $display("FAIL rerun_tidx: got %0d,%0d expected 0,1", tidx[13], tidx[25]);
    else n_pass++;
    n_total++;
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_res_stall();
    test_zero_tiles();
    test_ignored_inputs();
    test_reset_midjob();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
